load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage of the NPC core. Sits between the execute stage and the DPI-backed data memory (`RamDpi`). Accepts one load/store request per handshake, aligns address/data/mask for the word-wide memory port, and issues exactly one single-cycle memory access after a configurable wait. Extracts and extends the load result, then holds it for writeback under a valid/ready handshake.

## Interface
- `LATENCY`, default 0: extra wait cycles between request acceptance and the memory access cycle (0..15).
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `inValid`  in  1: request valid from execute.
- `inReady`  out  1: LSU can accept a request.
- `inIsLoad` / `inIsStore`  in  1 each: operation kind; both 0 or both 1 is an illegal request.
- `inFunct3`  in  3: RV32I width code (loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW).
- `inAddr`  in  32: byte address.
- `inWdata`  in  32: store data, LSB-aligned.
- `outValid`  out  1: response valid to writeback.
- `outReady`  in  1: writeback accepts response.
- `outData`  out  32: extended load result; 0 for stores and errors.
- `outErr`  out  1: request was misaligned or illegal; no memory access made.
- `memValid`  out  1: access strobe to memory.
- `memWriteEnable`  out  1: access is a write.
- `memReadAddr` / `memWriteAddr`  out  32 each: both `{addr[31:2], 2'b00}`.
- `memWriteData`  out  32: store data shifted into byte lanes.
- `memWriteMask`  out  4: byte-lane enables (also drive lane selection for reads).
- `memReadData`  in  32: full aligned word, valid combinationally while `memValid`=1.

## Operation
- States: IDLE, WAIT, ACCESS, RESP. Reset -> IDLE.
- IDLE: `inReady`=1 (forced 0 while `reset`=1). On `inValid`&&`inReady` latch kind, funct3, addr, wdata.
  - Illegal (bad kind combo, load funct3 011/110/111, store funct3 not in 000..010) or misaligned (half with addr[0]=1, word with addr[1:0]≠0) -> RESP with `outErr`=1, `outData`=0.
  - Else if `LATENCY`=0 -> ACCESS; else load counter with `LATENCY`-1, -> WAIT.
- WAIT: counter decrements each cycle; at 0 -> ACCESS.
- ACCESS (exactly one cycle): `memValid`=1, `memWriteEnable`=store. Register result: loads take `memReadData >> (8*addr[1:0])`, then LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW as-is; stores register 0. `outErr`=0. -> RESP.
- RESP: `outValid`=1; `outData`/`outErr` stable. On `outReady` -> IDLE.
- Mask: byte `4'b0001<<addr[1:0]`, half `4'b0011<<addr[1:0]`, word `4'b1111`. `memWriteData` = `inWdata << (8*addr[1:0])`.
- `memValid` = (state==ACCESS) && !`reset`; memory outputs held at latched values in all states, `memWriteEnable` 0 outside ACCESS.
- One outstanding request; no new request accepted until response consumed.

## Timing
- Reset values: `outValid`=0, `outData`=0, `outErr`=0, `memValid`=0, `memWriteEnable`=0, memory addr/data/mask=0, counter 0; `inReady`=1 from first cycle after reset deasserts.
- Accept at edge T: ACCESS in cycle T+1+`LATENCY`; `outValid` from cycle T+2+`LATENCY`. Error path: `outValid` from cycle T+1.
- Earliest next acceptance: edge after `outValid`&&`outReady`.
- Backpressure: RESP holds indefinitely; no memory activity.
- Reset in any state (incl. WAIT/ACCESS/RESP): next state IDLE, response dropped, no memory strobe in the reset cycle.

## Test plan
- LATENCY=0, LW addr 0x80000004, memReadData 0xDEADBEEF -> cycle T+1 `memValid`=1, readAddr 0x80000004, mask 1111, `memWriteEnable`=0; T+2 `outValid`=1, `outData`=0xDEADBEEF, `outErr`=0.
- LB then LBU addr 0x80000003, memReadData 0x80123456 -> `outData` 0xFFFFFF80 then 0x00000080; LH addr 0x80000002 same word -> 0xFFFF8012.
- SH addr 0x80000002, wdata 0x1234ABCD -> `memWriteMask` 1100, `memWriteData` 0xABCD0000, `memWriteEnable`=1 for exactly one cycle; response `outData`=0.
- LW addr 0x80000001 and load funct3 011 -> `memValid` never asserted; `outValid` at T+1 with `outErr`=1, `outData`=0.
- LATENCY=3, `outReady` low 5 cycles in RESP -> `memValid` only at T+4; `outValid`/`outData` stable, `inReady`=0 throughout; accepted on `outReady` rise, `inReady`=1 next cycle.
- LATENCY=3, `reset` pulsed during WAIT -> no `memValid` pulse, `outValid`=0, state IDLE, next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and the data memory.
// It takes one load/store request per handshake and aligns the address, the
// store data and the byte mask for the word-wide memory port. After LATENCY
// wait cycles it issues exactly one single-cycle memory access. It then
// extracts and extends the load result and holds it until writeback takes it.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   inValid/inReady         request handshake from execute
//   inIsLoad/inIsStore      operation kind (exactly one must be set)
//   inFunct3                RV32I width code
//   inAddr, inWdata         byte address and LSB-aligned store data
//   outValid/outReady       response handshake to writeback
//   outData, outErr         extended load result / error flag
//   memValid, memWriteEnable, memReadAddr, memWriteAddr,
//   memWriteData, memWriteMask, memReadData   word-wide memory port
module load_store_unit #(
   parameter int unsigned LATENCY = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inValid,
   output logic        inReady,
   input  logic        inIsLoad,
   input  logic        inIsStore,
   input  logic [2:0]  inFunct3,
   input  logic [31:0] inAddr,
   input  logic [31:0] inWdata,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] outData,
   output logic        outErr,
   output logic        memValid,
   output logic        memWriteEnable,
   output logic [31:0] memReadAddr,
   output logic [31:0] memWriteAddr,
   output logic [31:0] memWriteData,
   output logic [3:0]  memWriteMask,
   input  logic [31:0] memReadData
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // The counter holds the wait cycles still to go after the current one.
   // So it starts at LATENCY-1, and ACCESS follows the cycle where it reads 0.
   localparam logic [3:0] WAIT_INIT = (LATENCY == 32'd0) ? 4'd0 : 4'(LATENCY - 32'd1);

   // Byte-lane enables for an access of width code size[1:0] at byte offset off.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = 4'b0011 << off;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // A request is rejected for a bad kind combination, an unknown width code or
   // a misaligned halfword/word address.
   function automatic logic request_error(input logic is_load, input logic is_store,
                                          input logic [2:0] f3, input logic [1:0] off);
      logic bad_kind;
      logic bad_width;
      logic misaligned;
      bad_kind   = (is_load == is_store);
      bad_width  = is_load ? ((f3 == 3'b011) || (f3[2:1] == 2'b11))
                           : (f3[2] || (f3[1:0] == 2'b11));
      misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
      return bad_kind || bad_width || misaligned;
   endfunction

   // Move the addressed lane(s) down to bit 0 and sign- or zero-extend them.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                               input logic [1:0] off);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b100:  r = {24'd0, sh[7:0]};
         3'b101:  r = {16'd0, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   logic [1:0]  state_r;
   logic [3:0]  cnt_r;
   logic        is_store_r;
   logic [2:0]  funct3_r;
   logic [1:0]  offset_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;
   logic [3:0]  mem_mask_r;
   logic        out_valid_r;
   logic        out_err_r;
   logic [31:0] out_data_r;
   logic        accept_s;
   logic        req_err_s;

   // Request acceptance and legality of the incoming request.
   always_comb begin
      accept_s  = (state_r == S_IDLE) && inValid && !reset;
      req_err_s = request_error(inIsLoad, inIsStore, inFunct3, inAddr[1:0]);
   end

   // Handshake and strobe outputs. They are gated by reset so that nothing is
   // accepted or strobed during the reset cycle itself.
   assign inReady        = (state_r == S_IDLE) && !reset;
   assign memValid       = (state_r == S_ACCESS) && !reset;
   assign memWriteEnable = memValid && is_store_r;
   assign memReadAddr    = mem_addr_r;
   assign memWriteAddr   = mem_addr_r;
   assign memWriteData   = mem_wdata_r;
   assign memWriteMask   = mem_mask_r;
   assign outValid       = out_valid_r;
   assign outData        = out_data_r;
   assign outErr         = out_err_r;

   // Request FSM, latched memory-port values and the registered response.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= S_IDLE;
         cnt_r       <= 4'd0;
         is_store_r  <= 1'b0;
         funct3_r    <= 3'd0;
         offset_r    <= 2'd0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         mem_mask_r  <= 4'd0;
         out_valid_r <= 1'b0;
         out_err_r   <= 1'b0;
         out_data_r  <= 32'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  is_store_r  <= inIsStore;
                  funct3_r    <= inFunct3;
                  offset_r    <= inAddr[1:0];
                  mem_addr_r  <= {inAddr[31:2], 2'b00};
                  mem_wdata_r <= inWdata << {inAddr[1:0], 3'b000};
                  mem_mask_r  <= lane_mask(inFunct3[1:0], inAddr[1:0]);
                  if (req_err_s) begin
                     // Rejected requests skip the memory and answer at once.
                     state_r     <= S_RESP;
                     out_valid_r <= 1'b1;
                     out_err_r   <= 1'b1;
                     out_data_r  <= 32'd0;
                  end else if (LATENCY == 32'd0) begin
                     state_r <= S_ACCESS;
                  end else begin
                     cnt_r   <= WAIT_INIT;
                     state_r <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_r == 4'd0) begin
                  state_r <= S_ACCESS;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            S_ACCESS: begin
               out_valid_r <= 1'b1;
               out_err_r   <= 1'b0;
               out_data_r  <= is_store_r ? 32'd0 : load_extend(funct3_r, memReadData, offset_r);
               state_r     <= S_RESP;
            end
            S_RESP: begin
               if (outReady) begin
                  out_valid_r <= 1'b0;
                  state_r     <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: two instances of load_store_unit, one with LATENCY=0 and
// one with LATENCY=3. Each lane is described by a transaction-level model
// that tracks only "busy" and "cycles since acceptance" plus the expected
// result. The model works these out from the request with plain arithmetic.
// A negedge compare process checks every output of both lanes each cycle.
// Directed requests also pin hand-computed values.
module tb_load_store_unit;

   localparam int LAT [2] = '{0, 3};

   logic        clk = 1'b0;
   logic        rst [2];
   logic        in_valid [2];
   logic        in_is_load [2];
   logic        in_is_store [2];
   logic [2:0]  f3 [2];
   logic [31:0] in_addr [2];
   logic [31:0] in_wdata [2];
   logic        out_ready [2];
   logic [31:0] rdata [2];
   logic        in_ready [2];
   logic        out_valid [2];
   logic [31:0] out_data [2];
   logic        out_err [2];
   logic        mem_valid [2];
   logic        mem_we [2];
   logic [31:0] mem_raddr [2];
   logic [31:0] mem_waddr [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_mask [2];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // model state per lane
   bit          busy [2] = '{1'b0, 1'b0};
   int          age [2]  = '{0, 0};
   bit          m_err [2];
   bit          m_store [2];
   logic [31:0] m_data [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd [2];
   logic [3:0]  m_mask [2];

   // observed memory activity, used by the literal pins
   int          mv_count [2] = '{0, 0};
   logic [3:0]  last_mask [2];
   logic [31:0] last_wd [2];

   always #5 clk = ~clk;

   load_store_unit #(.LATENCY(0)) u_lat0 (
      .clock(clk), .reset(rst[0]), .inValid(in_valid[0]), .inReady(in_ready[0]),
      .inIsLoad(in_is_load[0]), .inIsStore(in_is_store[0]), .inFunct3(f3[0]),
      .inAddr(in_addr[0]), .inWdata(in_wdata[0]), .outValid(out_valid[0]),
      .outReady(out_ready[0]), .outData(out_data[0]), .outErr(out_err[0]),
      .memValid(mem_valid[0]), .memWriteEnable(mem_we[0]), .memReadAddr(mem_raddr[0]),
      .memWriteAddr(mem_waddr[0]), .memWriteData(mem_wdata[0]),
      .memWriteMask(mem_mask[0]), .memReadData(rdata[0]));

   load_store_unit #(.LATENCY(3)) u_lat3 (
      .clock(clk), .reset(rst[1]), .inValid(in_valid[1]), .inReady(in_ready[1]),
      .inIsLoad(in_is_load[1]), .inIsStore(in_is_store[1]), .inFunct3(f3[1]),
      .inAddr(in_addr[1]), .inWdata(in_wdata[1]), .outValid(out_valid[1]),
      .outReady(out_ready[1]), .outData(out_data[1]), .outErr(out_err[1]),
      .memValid(mem_valid[1]), .memWriteEnable(mem_we[1]), .memReadAddr(mem_raddr[1]),
      .memWriteAddr(mem_waddr[1]), .memWriteData(mem_wdata[1]),
      .memWriteMask(mem_mask[1]), .memReadData(rdata[1]));

   task automatic check(input string nm, input int ln, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d: actual=%h required=%h t=%0t", nm, ln, act, exp, $time);
      end
   endtask

   // Response is due once the model has waited long enough since acceptance.
   function automatic bit model_ov(input int ln);
      return busy[ln] && (age[ln] >= (m_err[ln] ? 1 : 2 + LAT[ln]));
   endfunction

   // Model update on each rising edge.
   logic [31:0] s_a, s_w, s_d;
   logic [2:0]  s_f;
   int          s_off, s_size;
   bit          s_ld, s_st, s_bad;
   always @(posedge clk) begin
      for (int ln = 0; ln < 2; ln++) begin
         if (rst[ln]) begin
            busy[ln] <= 1'b0;
         end else if (busy[ln]) begin
            if (model_ov(ln) && out_ready[ln]) busy[ln] <= 1'b0;
            else age[ln] <= age[ln] + 1;
         end else if (in_valid[ln]) begin
            s_a = in_addr[ln]; s_f = f3[ln]; s_ld = in_is_load[ln]; s_st = in_is_store[ln];
            s_off  = int'(s_a[1:0]);
            s_size = (s_f[1:0] == 2'd0) ? 1 : (s_f[1:0] == 2'd1) ? 2 : (s_f[1:0] == 2'd2) ? 4 : 0;
            s_bad  = (s_ld == s_st) ||
                     (s_ld && !(s_f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                     (s_st && !(s_f inside {3'd0, 3'd1, 3'd2})) ||
                     (s_size == 0) || ((s_off % ((s_size == 0) ? 1 : s_size)) != 0);
            s_w = rdata[ln] >> (8 * s_off);
            case (s_f)
               3'd0: begin s_d = s_w & 32'hFF;   if (s_d >= 32'd128)   s_d = s_d + 32'hFFFFFF00; end
               3'd1: begin s_d = s_w & 32'hFFFF; if (s_d >= 32'h8000) s_d = s_d + 32'hFFFF0000; end
               3'd4: s_d = s_w & 32'hFF;
               3'd5: s_d = s_w & 32'hFFFF;
               default: s_d = s_w;
            endcase
            if (s_bad || s_st) s_d = 32'd0;
            busy[ln]    <= 1'b1;
            age[ln]     <= 1;
            m_err[ln]   <= s_bad;
            m_store[ln] <= s_st;
            m_data[ln]  <= s_d;
            m_addr[ln]  <= s_a - 32'(s_off);
            m_wd[ln]    <= in_wdata[ln] << (8 * s_off);
            m_mask[ln]  <= (s_size == 4) ? 4'hF : 4'(((1 << s_size) - 1) << s_off);
         end
      end
   end

   // Compare process: every output of both lanes against the model, each cycle.
   logic emv, eov;
   always @(negedge clk) begin
      if (chk_en) begin
         for (int ln = 0; ln < 2; ln++) begin
            emv = busy[ln] && !m_err[ln] && (age[ln] == 1 + LAT[ln]) && !rst[ln];
            eov = model_ov(ln);
            check("inReady", ln, in_ready[ln], !busy[ln] && !rst[ln]);
            check("memValid", ln, mem_valid[ln], emv);
            check("memWriteEnable", ln, mem_we[ln], emv && m_store[ln]);
            check("outValid", ln, out_valid[ln], eov);
            if (mem_valid[ln]) begin
               mv_count[ln]++;
               last_mask[ln] = mem_mask[ln];
               last_wd[ln]   = mem_wdata[ln];
            end
            if (emv) begin
               check("memReadAddr", ln, mem_raddr[ln], m_addr[ln]);
               check("memWriteAddr", ln, mem_waddr[ln], m_addr[ln]);
               check("memWriteMask", ln, mem_mask[ln], m_mask[ln]);
               check("memWriteData", ln, mem_wdata[ln], m_wd[ln]);
            end
            if (eov) begin
               check("outData", ln, out_data[ln], m_data[ln]);
               check("outErr", ln, out_err[ln], m_err[ln]);
            end
         end
      end
   end

   // Issue one request, wait (bounded) for its response, hold backpressure for
   // 'hold' cycles, then complete the handshake. Optionally pins literals.
   task automatic do_req(input int ln, input bit ld, input bit st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int hold, input bit pin, input logic [31:0] pin_data,
                         input bit pin_err, input int pin_lat);
      int n;
      @(posedge clk); #2;
      in_valid[ln] = 1'b1; in_is_load[ln] = ld; in_is_store[ln] = st; f3[ln] = f;
      in_addr[ln] = a; in_wdata[ln] = wd; rdata[ln] = rd;
      @(posedge clk); #2;
      in_valid[ln] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid[ln] && n < 40);
      check("resp_seen", ln, out_valid[ln], 1'b1);
      if (pin) begin
         check("lit_latency", ln, n, pin_lat);
         check("lit_outData", ln, out_data[ln], pin_data);
         check("lit_outErr", ln, out_err[ln], pin_err);
      end
      repeat (hold) @(negedge clk);
      out_ready[ln] = 1'b1;
      @(posedge clk); #2;
      out_ready[ln] = 1'b0;
   endtask

   int mv_before;
   int kind;
   initial begin
      for (int ln = 0; ln < 2; ln++) begin
         rst[ln] = 1'b1; in_valid[ln] = 1'b0; in_is_load[ln] = 1'b0; in_is_store[ln] = 1'b0;
         f3[ln] = 3'd0; in_addr[ln] = 32'd0; in_wdata[ln] = 32'd0; out_ready[ln] = 1'b0;
         rdata[ln] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #2 chk_en = 1'b1;
      @(posedge clk); #2;
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      for (int ln = 0; ln < 2; ln++) begin
         check("rst_inReady", ln, in_ready[ln], 1'b1);
         check("rst_outValid", ln, out_valid[ln], 1'b0);
         check("rst_outData", ln, out_data[ln], 32'd0);
         check("rst_outErr", ln, out_err[ln], 1'b0);
         check("rst_memWE", ln, mem_we[ln], 1'b0);
         check("rst_memAddr", ln, mem_raddr[ln], 32'd0);
         check("rst_memData", ln, mem_wdata[ln], 32'd0);
         check("rst_memMask", ln, mem_mask[ln], 4'd0);
      end

      // LATENCY=0 directed cases
      do_req(0, 1'b1, 1'b0, 3'b010, 32'h80000004, 32'd0, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
      do_req(0, 1'b1, 1'b0, 3'b000, 32'h80000003, 32'd0, 32'h80123456, 0, 1'b1, 32'hFFFFFF80, 1'b0, 2);
      do_req(0, 1'b1, 1'b0, 3'b100, 32'h80000003, 32'd0, 32'h80123456, 0, 1'b1, 32'h00000080, 1'b0, 2);
      do_req(0, 1'b1, 1'b0, 3'b001, 32'h80000002, 32'd0, 32'h80123456, 0, 1'b1, 32'hFFFF8012, 1'b0, 2);
      mv_before = mv_count[0];
      do_req(0, 1'b0, 1'b1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'd0, 0, 1'b1, 32'd0, 1'b0, 2);
      check("lit_sh_strobes", 0, mv_count[0] - mv_before, 1);
      check("lit_sh_mask", 0, last_mask[0], 4'b1100);
      check("lit_sh_wdata", 0, last_wd[0], 32'hABCD0000);
      mv_before = mv_count[0];
      do_req(0, 1'b1, 1'b0, 3'b010, 32'h80000001, 32'd0, 32'h11111111, 0, 1'b1, 32'd0, 1'b1, 1);
      do_req(0, 1'b1, 1'b0, 3'b011, 32'h80000000, 32'd0, 32'h11111111, 0, 1'b1, 32'd0, 1'b1, 1);
      check("lit_err_no_strobe", 0, mv_count[0] - mv_before, 0);

      // LATENCY=3: backpressure, then reset during WAIT, then a normal request
      mv_before = mv_count[1];
      do_req(1, 1'b1, 1'b0, 3'b010, 32'h80000008, 32'd0, 32'hCAFEF00D, 5, 1'b1, 32'hCAFEF00D, 1'b0, 5);
      check("lit_bp_strobes", 1, mv_count[1] - mv_before, 1);
      mv_before = mv_count[1];
      @(posedge clk); #2;
      in_valid[1] = 1'b1; in_is_load[1] = 1'b1; in_is_store[1] = 1'b0; f3[1] = 3'b010;
      in_addr[1] = 32'h8000000C; rdata[1] = 32'h55AA55AA;
      @(posedge clk); #2;
      in_valid[1] = 1'b0;
      @(posedge clk); #2;
      rst[1] = 1'b1;
      @(posedge clk); #2;
      rst[1] = 1'b0;
      repeat (6) @(negedge clk);
      check("lit_rst_no_strobe", 1, mv_count[1] - mv_before, 0);
      check("lit_rst_outValid", 1, out_valid[1], 1'b0);
      check("lit_rst_inReady", 1, in_ready[1], 1'b1);
      do_req(1, 1'b1, 1'b0, 3'b101, 32'h80000002, 32'd0, 32'hFFFF0000, 0, 1'b1, 32'h0000FFFF, 1'b0, 5);

      // randomized requests on both lanes, checked by the model
      for (int i = 0; i < 120; i++) begin
         kind = int'($urandom_range(0, 9));
         do_req(i % 2, (kind == 1) || (kind >= 6), (kind == 1) || (kind >= 2 && kind <= 5),
                3'($urandom_range(0, 7)), {24'h800000, 8'($urandom)}, $urandom, $urandom,
                int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0, 0);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
